// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding, default width and
// a constant-foldable ceil(log2) helper for sizing counters.
package arith_pkg;

   localparam int unsigned DefWidth = 4;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result buses of the serial subtractor.
interface serial_subtractor_if
   import arith_pkg::*;
#(
   parameter int unsigned N = DefWidth
);

   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         bout;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout
   );

endinterface

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
   input  logic i_a,
   input  logic i_b,
   input  logic i_bin,
   output logic o_d,
   output logic o_bout
);

   assign o_d    = i_a ^ i_b ^ i_bin;
   assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor (A - B - Bin), LSB first, one bit per cycle,
// behind a start/busy/done handshake.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int unsigned N = DefWidth
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int unsigned     CntW    = clog2(N);
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   state_e          r_state;
   state_e          w_state_next;
   logic [N-1:0]    r_a_sr;
   logic [N-1:0]    r_b_sr;
   logic [N-1:0]    r_res;
   logic [N-1:0]    r_diff;
   logic [CntW-1:0] r_cnt;
   logic            r_borrow;
   logic            r_bout;

   logic            w_accept;
   logic            w_last;
   logic            w_d;
   logic            w_bnext;
   logic [N-1:0]    w_res_next;
   logic            w_unused_res0;

   assign w_accept   = bus.start && ((r_state == StIdle) || (r_state == StDone));
   assign w_last     = (r_cnt == CntLast);
   assign w_res_next = {w_d, r_res[N-1:1]};
   // The oldest result bit falls off the shift register and is never needed.
   assign w_unused_res0 = r_res[0];

   full_subtractor u_fs (
      .i_a    (r_a_sr[0]),
      .i_b    (r_b_sr[0]),
      .i_bin  (r_borrow),
      .o_d    (w_d),
      .o_bout (w_bnext)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (bus.start) w_state_next = StRun;
         StRun:   if (w_last) w_state_next = StDone;
         StDone:  w_state_next = bus.start ? StRun : StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      bus.busy = (r_state == StRun);
      bus.done = (r_state == StDone);
      bus.diff = r_diff;
      bus.bout = r_bout;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_res    <= '0;
         r_diff   <= '0;
         r_cnt    <= '0;
         r_borrow <= 1'b0;
         r_bout   <= 1'b0;
      end else if (w_accept) begin
         r_a_sr   <= bus.a;
         r_b_sr   <= bus.b;
         r_borrow <= bus.bin;
         r_cnt    <= '0;
      end else if (r_state == StRun) begin
         r_a_sr   <= {1'b0, r_a_sr[N-1:1]};
         r_b_sr   <= {1'b0, r_b_sr[N-1:1]};
         r_res    <= w_res_next;
         r_borrow <= w_bnext;
         r_cnt    <= r_cnt + CntW'(1);
         // Outputs update only on the edge that enters the done cycle.
         if (w_last) begin
            r_diff <= w_res_next;
            r_bout <= w_bnext;
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N = 4).
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   serial_subtractor_if #(.N(W)) bus ();

   serial_subtractor #(.N(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation from IDLE/DONE and check the full handshake timeline.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin_v,
                         input logic [W-1:0] exp_d, input logic exp_b, input string tag);
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin_v;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a     = ~a;
      bus.b     = ~b;
      bus.bin   = ~bin_v;
      chk({tag, "_busy0"}, 32'({bus.busy, bus.done}), 32'b10);
      for (int i = 1; i < int'(W); i++) begin
         tick();
         chk({tag, "_busy"}, 32'({bus.busy, bus.done}), 32'b10);
      end
      tick();
      chk({tag, "_done"}, 32'({bus.busy, bus.done}), 32'b01);
      chk({tag, "_diff"}, 32'(bus.diff), 32'(exp_d));
      chk({tag, "_bout"}, 32'(bus.bout), 32'(exp_b));
   endtask

   initial begin
      int          dones;
      logic [4:0]  model;

      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_diff", 32'(bus.diff), 32'd0);
      chk("rst_bout", 32'(bus.bout), 32'd0);
      tick();
      chk("idle_busy", 32'(bus.busy), 32'd0);

      run_op(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, "9m3");
      tick();
      chk("after_done", 32'({bus.busy, bus.done}), 32'b00);
      chk("hold_diff", 32'(bus.diff), 32'd6);
      run_op(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, "3m9");
      run_op(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, "0m0b");
      run_op(4'd15, 4'd15, 1'b1, 4'hF, 1'b1, "fmfb");
      tick();

      // start during RUN must be ignored
      bus.a     = 4'd7;
      bus.b     = 4'd2;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.a = 4'd1;
      bus.b = 4'd1;
      for (int i = 1; i < int'(W); i++) begin
         tick();
         chk("ign_busy", 32'({bus.busy, bus.done}), 32'b10);
      end
      tick();
      chk("ign_done", 32'(bus.done), 32'd1);
      chk("ign_diff", 32'(bus.diff), 32'd5);
      chk("ign_bout", 32'(bus.bout), 32'd0);
      bus.start = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done) dones++;
      end
      chk("ign_extra_done", 32'(dones), 32'd0);
      chk("ign_idle", 32'(bus.busy), 32'd0);

      // reset in the 2nd RUN cycle aborts the operation
      bus.a     = 4'd12;
      bus.b     = 4'd5;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_diff", 32'(bus.diff), 32'd0);
      chk("abort_bout", 32'(bus.bout), 32'd0);
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done) dones++;
      end
      chk("abort_no_done", 32'(dones), 32'd0);

      // start held high: one result every N+1 cycles
      bus.a     = 4'd8;
      bus.b     = 4'd1;
      bus.bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      for (int rep = 0; rep < 3; rep++) begin
         chk("b2b_busy0", 32'({bus.busy, bus.done}), 32'b10);
         for (int i = 1; i < int'(W); i++) begin
            tick();
            chk("b2b_busy", 32'({bus.busy, bus.done}), 32'b10);
         end
         tick();
         chk("b2b_done", 32'({bus.busy, bus.done}), 32'b01);
         chk("b2b_diff", 32'(bus.diff), 32'd7);
         chk("b2b_bout", 32'(bus.bout), 32'd0);
         if (rep == 2) bus.start = 1'b0;
         tick();
      end
      chk("b2b_idle", 32'({bus.busy, bus.done}), 32'b00);

      // exhaustive sweep against an arithmetic model
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int c = 0; c < 2; c++) begin
               model = 5'(a) - 5'(b) - 5'(c);
               run_op(4'(a), 4'(b), 1'(c), model[3:0], model[4], "sweep");
            end
         end
      end
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
